// File: rtl/trap_csr_pkg.sv
// Shared CSR addresses, CSR operation codes and trap cause codes for the trap/CSR block.
package trap_csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [4:0] TRAP_INS_MISALIGN   = 5'd0;
    localparam logic [4:0] TRAP_ILLEGAL        = 5'd2;
    localparam logic [4:0] TRAP_BREAK          = 5'd3;
    localparam logic [4:0] TRAP_LOAD_MISALIGN  = 5'd4;
    localparam logic [4:0] TRAP_STORE_MISALIGN = 5'd6;
    localparam logic [4:0] TRAP_ECALL_M        = 5'd11;

    // Read-modify-write result of a CSR operation on the current value.
    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                              input logic [31:0] operand);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = operand;
            CSR_OP_SET:   res = old_val | operand;
            CSR_OP_CLEAR: res = old_val & ~operand;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/trap_csr_if.sv
// CSR access bus between the instruction pipeline (master) and the CSR file (slave).
interface trap_csr_if;
    trap_csr_pkg::csr_op_e csr_op;
    logic [11:0]           csr_addr;
    logic [31:0]           csr_wdata;
    logic [31:0]           csr_rdata;
    logic                  csr_illegal;

    modport master (
        output csr_op, csr_addr, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_op, csr_addr, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/trap_csr_counter64.sv
// 64-bit event counter with split 32-bit writes; a high-half write suppresses the carry.
module counter64 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_value
);

    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic [32:0] w_lo_sum;

    assign w_lo_sum = {1'b0, r_lo} + {32'b0, i_inc};
    assign o_value  = {r_hi, r_lo};

    // Count, or load one half; a low write replaces the increment, a high write drops the carry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lo <= '0;
            r_hi <= '0;
        end else if (i_wr_lo) begin
            r_lo <= i_wdata;
        end else if (i_wr_hi) begin
            r_hi <= i_wdata;
            r_lo <= w_lo_sum[31:0];
        end else begin
            r_lo <= w_lo_sum[31:0];
            r_hi <= r_hi + {31'b0, w_lo_sum[32]};
        end
    end

endmodule

// File: rtl/trap_csr.sv
// Machine-mode trap CSR file: mstatus/mtvec/mscratch/mepc/mcause/mtval plus cycle and
// retired-instruction counters. Trap entry beats mret, which beats a CSR access.
module trap_csr
    import trap_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned MEPC_ALIGN  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    trap_csr_if.slave   csr_bus,
    input  logic        i_trap_taken,
    input  logic [4:0]  i_trap_src,
    input  logic [31:0] i_trap_pc,
    input  logic [31:0] i_trap_tval,
    input  logic        i_mret,
    input  logic        i_retire,
    output logic [31:0] o_mtvec_rdata,
    output logic [31:0] o_mepc_rdata,
    output logic        o_mie
);

    localparam logic [31:0] MEPC_MASK  = ~((32'd1 << MEPC_ALIGN) - 32'd1);
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;

    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic        r_mie;
    logic        r_mpie;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_mstatus;
    logic [31:0] w_rdata;
    logic        w_mapped;
    logic        w_illegal;
    logic        w_we;
    logic [31:0] w_new;
    logic        w_wr_mstatus, w_wr_mtvec, w_wr_mscratch, w_wr_mepc, w_wr_mcause, w_wr_mtval;
    logic        w_wr_mcycle, w_wr_mcycleh, w_wr_minstret, w_wr_minstreth;

    // MPP is hardwired to machine mode; only MIE and MPIE are storage.
    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};

    // Combinational read of the addressed CSR, pre-update value; flags unmapped addresses.
    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        case (csr_bus.csr_addr)
            CSR_MSTATUS:   w_rdata = w_mstatus;
            CSR_MTVEC:     w_rdata = r_mtvec;
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = r_mepc;
            CSR_MCAUSE:    w_rdata = r_mcause;
            CSR_MTVAL:     w_rdata = r_mtval;
            CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
            CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
            CSR_MINSTRET:  w_rdata = w_minstret[31:0];
            CSR_MINSTRETH: w_rdata = w_minstret[63:32];
            CSR_MHARTID:   w_rdata = '0;
            default:       w_mapped = 1'b0;
        endcase
    end

    assign w_illegal = (csr_bus.csr_op != CSR_OP_NONE) &&
                       (!w_mapped || (csr_bus.csr_addr[11:10] == 2'b11));
    assign w_we      = (csr_bus.csr_op != CSR_OP_NONE) && !w_illegal;
    assign w_new     = csr_apply(csr_bus.csr_op, w_rdata, csr_bus.csr_wdata);

    assign csr_bus.csr_rdata   = w_rdata;
    assign csr_bus.csr_illegal = w_illegal;

    assign w_wr_mstatus   = w_we && (csr_bus.csr_addr == CSR_MSTATUS);
    assign w_wr_mtvec     = w_we && (csr_bus.csr_addr == CSR_MTVEC);
    assign w_wr_mscratch  = w_we && (csr_bus.csr_addr == CSR_MSCRATCH);
    assign w_wr_mepc      = w_we && (csr_bus.csr_addr == CSR_MEPC);
    assign w_wr_mcause    = w_we && (csr_bus.csr_addr == CSR_MCAUSE);
    assign w_wr_mtval     = w_we && (csr_bus.csr_addr == CSR_MTVAL);
    assign w_wr_mcycle    = w_we && (csr_bus.csr_addr == CSR_MCYCLE);
    assign w_wr_mcycleh   = w_we && (csr_bus.csr_addr == CSR_MCYCLEH);
    assign w_wr_minstret  = w_we && (csr_bus.csr_addr == CSR_MINSTRET);
    assign w_wr_minstreth = w_we && (csr_bus.csr_addr == CSR_MINSTRETH);

    counter64 u_mcycle (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr_mcycle),
        .i_wr_hi (w_wr_mcycleh),
        .i_wdata (w_new),
        .o_value (w_mcycle)
    );

    counter64 u_minstret (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (i_retire),
        .i_wr_lo (w_wr_minstret),
        .i_wr_hi (w_wr_minstreth),
        .i_wdata (w_new),
        .o_value (w_minstret)
    );

    // Trap-owned CSRs: trap entry overrides mret, and both override software writes to them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
        end else begin
            if (i_trap_taken) begin
                r_mepc   <= i_trap_pc & MEPC_MASK;
                r_mcause <= {27'b0, i_trap_src};
                r_mtval  <= i_trap_tval;
            end else begin
                if (w_wr_mepc)   r_mepc   <= w_new & MEPC_MASK;
                if (w_wr_mcause) r_mcause <= w_new;
                if (w_wr_mtval)  r_mtval  <= w_new;
            end

            if (i_trap_taken) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
            end else if (i_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wr_mstatus) begin
                r_mie  <= w_new[3];
                r_mpie <= w_new[7];
            end
        end
    end

    // Software-only CSRs, unaffected by trap entry or return.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mtvec    <= MTVEC_RESET & MTVEC_MASK;
            r_mscratch <= '0;
        end else begin
            if (w_wr_mtvec)    r_mtvec    <= w_new & MTVEC_MASK;
            if (w_wr_mscratch) r_mscratch <= w_new;
        end
    end

    assign o_mtvec_rdata = r_mtvec;
    assign o_mepc_rdata  = r_mepc;
    assign o_mie         = r_mie;

endmodule

// File: tb/tb_trap_csr.sv
// Self-checking bench for trap_csr: vector table for CSR/trap behaviour, hand sequences
// for counter write/carry/wrap corners and asynchronous reset.
module tb_trap_csr;
    import trap_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_taken;
    logic [4:0]  trap_src;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        retire;
    logic [31:0] mtvec_rdata;
    logic [31:0] mepc_rdata;
    logic        mie;

    always #5 clk = ~clk;

    trap_csr_if bus ();

    trap_csr #(
        .MTVEC_RESET (32'h0000_1003),
        .MEPC_ALIGN  (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .csr_bus       (bus),
        .i_trap_taken  (trap_taken),
        .i_trap_src    (trap_src),
        .i_trap_pc     (trap_pc),
        .i_trap_tval   (trap_tval),
        .i_mret        (mret),
        .i_retire      (retire),
        .o_mtvec_rdata (mtvec_rdata),
        .o_mepc_rdata  (mepc_rdata),
        .o_mie         (mie)
    );

    typedef struct {
        csr_op_e     op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        trap;
        logic [4:0]  src;
        logic [31:0] pc;
        logic [31:0] tval;
        logic        mret;
        logic        retire;
        logic        chk_rd;
        logic [31:0] e_rd;
        logic        e_ill;
        logic [31:0] e_mtvec;
        logic [31:0] e_mepc;
        logic        e_mie;
    } vec_t;

    typedef struct {
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        mie;
    } post_t;

    post_t       sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] s_mtvec;
    logic [31:0] s_mepc;
    logic        s_mie;
    vec_t        tbl[30];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input csr_op_e op, input logic [11:0] a, input logic [31:0] wd,
                                 input logic tr, input logic [4:0] src, input logic [31:0] pc,
                                 input logic [31:0] tv, input logic mr, input logic [31:0] erd,
                                 input logic eill, input logic [31:0] emt, input logic [31:0] emp,
                                 input logic emie);
        vec_t v;
        v = '{op: op, addr: a, wdata: wd, trap: tr, src: src, pc: pc, tval: tv, mret: mr,
              retire: 1'b0, chk_rd: 1'b1, e_rd: erd, e_ill: eill, e_mtvec: emt, e_mepc: emp,
              e_mie: emie};
        return v;
    endfunction

    function automatic vec_t mkc(input csr_op_e op, input logic [11:0] a, input logic [31:0] wd,
                                 input logic ret, input logic chk, input logic [31:0] erd);
        vec_t v;
        v = '{op: op, addr: a, wdata: wd, trap: 1'b0, src: 5'd0, pc: 32'h0, tval: 32'h0,
              mret: 1'b0, retire: ret, chk_rd: chk, e_rd: erd, e_ill: 1'b0, e_mtvec: s_mtvec,
              e_mepc: s_mepc, e_mie: s_mie};
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        post_t p;
        @(negedge clk);
        bus.csr_op    = v.op;
        bus.csr_addr  = v.addr;
        bus.csr_wdata = v.wdata;
        trap_taken    = v.trap;
        trap_src      = v.src;
        trap_pc       = v.pc;
        trap_tval     = v.tval;
        mret          = v.mret;
        retire        = v.retire;
        #1;
        if (v.chk_rd) check($sformatf("rdata[%0d]", idx), bus.csr_rdata, v.e_rd);
        check($sformatf("illegal[%0d]", idx), {31'b0, bus.csr_illegal}, {31'b0, v.e_ill});
        sb.push_back('{mtvec: v.e_mtvec, mepc: v.e_mepc, mie: v.e_mie});
        @(posedge clk);
        #1;
        p = sb.pop_front();
        check($sformatf("mtvec[%0d]", idx), mtvec_rdata, p.mtvec);
        check($sformatf("mepc[%0d]", idx), mepc_rdata, p.mepc);
        check($sformatf("mie[%0d]", idx), {31'b0, mie}, {31'b0, p.mie});
    endtask

    // Reset-state reads through the CSR bus, no clock edge involved.
    task automatic check_reset_state(input string tag);
        logic [11:0] addrs [10];
        logic [31:0] exps  [10];
        addrs = '{12'h300, 12'h341, 12'h342, 12'h343, 12'h340, 12'hB00, 12'hB80, 12'hB02,
                  12'hB82, 12'h305};
        exps  = '{32'h1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1000};
        check({tag, "_mtvec"}, mtvec_rdata, 32'h1000);
        check({tag, "_mepc"}, mepc_rdata, 32'h0);
        check({tag, "_mie"}, {31'b0, mie}, 32'h0);
        bus.csr_op = CSR_OP_NONE;
        for (int i = 0; i < 10; i++) begin
            bus.csr_addr = addrs[i];
            #1;
            check($sformatf("%s_rd_%h", tag, addrs[i]), bus.csr_rdata, exps[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        bus.csr_op    = CSR_OP_NONE;
        bus.csr_addr  = '0;
        bus.csr_wdata = '0;
        trap_taken    = 1'b0;
        trap_src      = '0;
        trap_pc       = '0;
        trap_tval     = '0;
        mret          = 1'b0;
        retire        = 1'b0;

        //        op            addr     wdata         tr    src    pc            tval          mr    rdata         ill   mtvec         mepc          mie
        tbl[0]  = mkv(CSR_OP_SET,   12'h300, 32'h8,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1800,     1'b0, 32'h1000,     32'h0,        1'b1);
        tbl[1]  = mkv(CSR_OP_NONE,  12'h300, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1808,     1'b0, 32'h1000,     32'h0,        1'b1);
        tbl[2]  = mkv(CSR_OP_NONE,  12'h341, 32'h0,        1'b1, 5'd2,  32'h104,      32'hDEAD,     1'b0, 32'h0,        1'b0, 32'h1000,     32'h104,      1'b0);
        tbl[3]  = mkv(CSR_OP_NONE,  12'h342, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h2,        1'b0, 32'h1000,     32'h104,      1'b0);
        tbl[4]  = mkv(CSR_OP_NONE,  12'h343, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'hDEAD,     1'b0, 32'h1000,     32'h104,      1'b0);
        tbl[5]  = mkv(CSR_OP_NONE,  12'h300, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1880,     1'b0, 32'h1000,     32'h104,      1'b0);
        tbl[6]  = mkv(CSR_OP_NONE,  12'h300, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 32'h1880,     1'b0, 32'h1000,     32'h104,      1'b1);
        tbl[7]  = mkv(CSR_OP_NONE,  12'h300, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1888,     1'b0, 32'h1000,     32'h104,      1'b1);
        tbl[8]  = mkv(CSR_OP_WRITE, 12'h341, 32'h200,      1'b1, 5'd11, 32'h208,      32'h0,        1'b0, 32'h104,      1'b0, 32'h1000,     32'h208,      1'b0);
        tbl[9]  = mkv(CSR_OP_NONE,  12'h342, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'hB,        1'b0, 32'h1000,     32'h208,      1'b0);
        tbl[10] = mkv(CSR_OP_CLEAR, 12'h300, 32'h8,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 32'h1880,     1'b0, 32'h1000,     32'h208,      1'b1);
        tbl[11] = mkv(CSR_OP_WRITE, 12'h305, 32'h8000_0103,1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1000,     1'b0, 32'h8000_0100,32'h208,      1'b1);
        tbl[12] = mkv(CSR_OP_WRITE, 12'hF14, 32'h5,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 32'h8000_0100,32'h208,      1'b1);
        tbl[13] = mkv(CSR_OP_NONE,  12'h7C0, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h8000_0100,32'h208,      1'b1);
        tbl[14] = mkv(CSR_OP_SET,   12'h7C0, 32'h1,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 32'h8000_0100,32'h208,      1'b1);
        tbl[15] = mkv(CSR_OP_WRITE, 12'h341, 32'h307,      1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h208,      1'b0, 32'h8000_0100,32'h304,      1'b1);
        tbl[16] = mkv(CSR_OP_WRITE, 12'h340, 32'h1234_5678,1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h8000_0100,32'h304,      1'b1);
        tbl[17] = mkv(CSR_OP_CLEAR, 12'h340, 32'hFF,       1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1234_5678,1'b0, 32'h8000_0100,32'h304,      1'b1);
        tbl[18] = mkv(CSR_OP_NONE,  12'h340, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1234_5600,1'b0, 32'h8000_0100,32'h304,      1'b1);
        tbl[19] = mkv(CSR_OP_WRITE, 12'h340, 32'hAAAA,     1'b1, 5'd4,  32'h402,      32'h55,       1'b0, 32'h1234_5600,1'b0, 32'h8000_0100,32'h400,      1'b0);
        tbl[20] = mkv(CSR_OP_NONE,  12'h340, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'hAAAA,     1'b0, 32'h8000_0100,32'h400,      1'b0);
        tbl[21] = mkv(CSR_OP_NONE,  12'h343, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h55,       1'b0, 32'h8000_0100,32'h400,      1'b0);
        tbl[22] = mkv(CSR_OP_WRITE, 12'h300, 32'hFFFF_FFFF,1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1880,     1'b0, 32'h8000_0100,32'h400,      1'b1);
        tbl[23] = mkv(CSR_OP_NONE,  12'h300, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1888,     1'b0, 32'h8000_0100,32'h400,      1'b1);
        tbl[24] = mkv(CSR_OP_WRITE, 12'h300, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1888,     1'b0, 32'h8000_0100,32'h400,      1'b0);
        tbl[25] = mkv(CSR_OP_NONE,  12'h300, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1800,     1'b0, 32'h8000_0100,32'h400,      1'b0);
        tbl[26] = mkv(CSR_OP_SET,   12'h305, 32'h3,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h8000_0100,1'b0, 32'h8000_0100,32'h400,      1'b0);
        tbl[27] = mkv(CSR_OP_NONE,  12'hF14, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h8000_0100,32'h400,      1'b0);
        tbl[28] = mkv(CSR_OP_NONE,  12'h300, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 32'h1800,     1'b0, 32'h8000_0100,32'h400,      1'b0);
        tbl[29] = mkv(CSR_OP_NONE,  12'h300, 32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h1880,     1'b0, 32'h8000_0100,32'h400,      1'b0);

        // Reset held across a clock edge: reset values visible.
        #12;
        check_reset_state("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 30; i++) apply(tbl[i], i);

        s_mtvec = 32'h8000_0100;
        s_mepc  = 32'h400;
        s_mie   = 1'b0;

        // mcycle: carry from low into high two edges after loading 0xFFFF_FFFF.
        apply(mkc(CSR_OP_WRITE, 12'hB80, 32'h0,         1'b0, 1'b1, 32'h0),         100);
        apply(mkc(CSR_OP_WRITE, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0),         101);
        apply(mkc(CSR_OP_NONE,  12'hB00, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF), 102);
        apply(mkc(CSR_OP_NONE,  12'hB80, 32'h0,         1'b0, 1'b1, 32'h1),         103);
        apply(mkc(CSR_OP_NONE,  12'hB00, 32'h0,         1'b0, 1'b1, 32'h1),         104);
        // High-half write on a low overflow: carry suppressed, low still wraps.
        apply(mkc(CSR_OP_WRITE, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0),         105);
        apply(mkc(CSR_OP_WRITE, 12'hB80, 32'h5,         1'b0, 1'b1, 32'h1),         106);
        apply(mkc(CSR_OP_NONE,  12'hB00, 32'h0,         1'b0, 1'b1, 32'h0),         107);
        apply(mkc(CSR_OP_NONE,  12'hB80, 32'h0,         1'b0, 1'b1, 32'h5),         108);
        // Full 64-bit wrap to zero.
        apply(mkc(CSR_OP_WRITE, 12'hB80, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h5),         109);
        apply(mkc(CSR_OP_WRITE, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0),         110);
        apply(mkc(CSR_OP_NONE,  12'hB80, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF), 111);
        apply(mkc(CSR_OP_NONE,  12'hB00, 32'h0,         1'b0, 1'b1, 32'h0),         112);
        apply(mkc(CSR_OP_NONE,  12'hB80, 32'h0,         1'b0, 1'b1, 32'h0),         113);
        // Low-half write replaces that cycle's increment.
        apply(mkc(CSR_OP_WRITE, 12'hB00, 32'h10,        1'b0, 1'b0, 32'h0),         114);
        apply(mkc(CSR_OP_NONE,  12'hB00, 32'h0,         1'b0, 1'b1, 32'h10),        115);

        // minstret: retire gating, write suppresses increment, reach 5.
        apply(mkc(CSR_OP_WRITE, 12'hB02, 32'h0,         1'b1, 1'b1, 32'h0),         120);
        apply(mkc(CSR_OP_WRITE, 12'hB82, 32'h0,         1'b1, 1'b1, 32'h0),         121);
        apply(mkc(CSR_OP_NONE,  12'hB02, 32'h0,         1'b1, 1'b1, 32'h1),         122);
        apply(mkc(CSR_OP_NONE,  12'hB02, 32'h0,         1'b1, 1'b1, 32'h2),         123);
        apply(mkc(CSR_OP_NONE,  12'hB02, 32'h0,         1'b1, 1'b1, 32'h3),         124);
        apply(mkc(CSR_OP_NONE,  12'hB02, 32'h0,         1'b0, 1'b1, 32'h4),         125);
        apply(mkc(CSR_OP_NONE,  12'hB02, 32'h0,         1'b1, 1'b1, 32'h4),         126);
        apply(mkc(CSR_OP_NONE,  12'hB82, 32'h0,         1'b0, 1'b1, 32'h0),         127);
        apply(mkc(CSR_OP_NONE,  12'hB02, 32'h0,         1'b0, 1'b1, 32'h5),         128);

        // Asynchronous reset in the middle of a trap cycle, no edge before the checks.
        @(negedge clk);
        trap_taken = 1'b1;
        trap_src   = TRAP_ILLEGAL;
        trap_pc    = 32'h0000_0600;
        trap_tval  = 32'h0000_0BAD;
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("async");
        trap_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        s_mtvec = 32'h1000;
        s_mepc  = 32'h0;
        s_mie   = 1'b0;
        apply(mkc(CSR_OP_NONE, 12'hB00, 32'h0, 1'b0, 1'b1, 32'h0), 130);
        apply(mkc(CSR_OP_NONE, 12'hB00, 32'h0, 1'b0, 1'b1, 32'h1), 131);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trap_csr.md
TRAP_CSR -- requirements
Module: trap_csr

Interface
REQ-001 Parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec (bits [1:0] ignored).
REQ-002 Parameter MEPC_ALIGN, default 2, number of mepc LSBs forced to zero.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 csr_op  input  2  00 none, 01 write, 10 set, 11 clear.
REQ-006 csr_addr  input  12  CSR address.
REQ-007 csr_wdata  input  32  write/set/clear operand.
REQ-008 csr_rdata  output  32  combinational read of csr_addr, pre-update value.
REQ-009 csr_illegal  output  1  combinational: csr_op!=00 and address unmapped, or write/set/clear to address[11:10]==2'b11.
REQ-010 trap_taken  input  1  trap commit strobe from the jump/trap unit.
REQ-011 trap_src  input  5  trap cause code (TRAP_* values).
REQ-012 trap_pc  input  32  PC of the trapping instruction.
REQ-013 trap_tval  input  32  faulting address or instruction bits.
REQ-014 mret  input  1  trap-return strobe.
REQ-015 retire  input  1  one instruction retired this cycle.
REQ-016 mtvec_rdata  output  32  current mtvec, to the jump unit.
REQ-017 mepc_rdata  output  32  current mepc, return target for mret.
REQ-018 mie  output  1  current mstatus.MIE.

Function
REQ-019 Mapped CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14 (reads 0).
REQ-020 Write: new = wdata; set: new = old | wdata; clear: new = old & ~wdata; applied at next edge when csr_illegal low.
REQ-021 mstatus implements only MIE (bit 3), MPIE (bit 7), MPP (bits 12:11, hardwired 2'b11); other bits read 0, writes ignored.
REQ-022 mtvec and mepc: written LSBs forced to zero (mtvec [1:0], mepc [MEPC_ALIGN-1:0]).
REQ-023 Trap entry (trap_taken=1): mepc<=trap_pc (aligned), mcause<={27'b0,trap_src}, mtval<=trap_tval, MPIE<=MIE, MIE<=0, one edge, no stall.
REQ-024 mret (trap_taken=0): MIE<=MPIE, MPIE<=1, one edge; mepc unchanged.
REQ-025 Priority same cycle: trap_taken > mret > CSR write; lower-priority updates to overlapping CSRs are dropped; CSR writes to non-trap CSRs (mscratch, mtvec, counters) still apply.
REQ-026 mcycle: 64-bit, increments every cycle out of reset, wraps 2^64-1 -> 0.
REQ-027 minstret: 64-bit, increments when retire=1, wraps.
REQ-028 Counter write to low half: low<=new value, high unchanged, no increment that cycle; write to high half: high<=new value, low still increments with no carry into high that cycle.
REQ-029 csr_rdata of a counter returns the pre-increment value of the cycle.
REQ-030 Unmapped read: csr_rdata=0.

Reset
REQ-031 While rst_n low: mtvec=MTVEC_RESET&~3, MIE=0, MPIE=0, mepc=0, mcause=0, mtval=0, mscratch=0, mcycle=0, minstret=0.
REQ-032 Reset asserted mid-operation discards any pending update; counters resume from 0 on the first edge after release.

Structure
REQ-033 CSR address constants and csr_op codes in shared header csr.vh; trap cause codes stay in jump.vh (illegal=2, ins misalign=0, M-ecall=11, break=3, load misalign=4, store misalign=6).
REQ-034 One sub-module counter64 (64-bit counter, increment enable, split low/high write with carry suppression), instanced for mcycle and minstret.

Verification
REQ-035 Reset, MIE set via csr set 0x300 wdata 8; trap_taken, trap_src=2, trap_pc=32'h104, tval=32'hDEAD -> mepc=0x104, mcause=2, mtval=0xDEAD, MIE=0, MPIE=1.
REQ-036 After REQ-035, mret -> MIE=1, MPIE=1, mepc_rdata still 0x104.
REQ-037 Same cycle trap_taken(src=11) and csr write 0x341 wdata 0x200 -> mepc=trap_pc, 0x200 dropped; same cycle mret and csr clear 0x300 wdata 8 -> MIE=MPIE.
REQ-038 Write mcycle 0xB00 wdata 32'hFFFF_FFFF, mcycleh 0 -> two edges later mcycleh=1, mcycle=1.
REQ-039 Write 0x305 wdata 32'h8000_0103 -> mtvec_rdata=32'h8000_0100; write 0xF14 -> csr_illegal=1, no state change; read 0x7C0 -> rdata 0, illegal only if csr_op!=00.
REQ-040 Assert rst_n low mid-trap with minstret=5 -> all REQ-031 values immediately, no clock needed.
